// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with a per-register busy scoreboard for an in-order
//   issue / out-of-order writeback pipeline.
//
//   R0 is hard-wired to zero and is never busy.
//   Both read ports are combinational.
//   An issue reserves its destination register (busy=1).
//   A writeback stores the data and releases the register.
//   busy_cnt is a registered count of the busy registers.
//
//   Optional feature (compile-time macro REGFILE_BYPASS_EN):
//     A same-cycle writeback is forwarded to a read port whose address
//     matches. That port then also reads not-busy.
//     Without the macro, reads return the stored (pre-write) state.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   addr_a/data_a/busy_a     read port A: address, data, busy flag
//   addr_b/data_b/busy_b     read port B: address, data, busy flag
//   write_en/addr_w/data_w   writeback strobe, address, data
//   issue_en/issue_addr      reserve a destination register
//   issue_stall              destination already busy, issue refused
//   busy_cnt                 number of busy registers (registered)
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  output logic              busy_b,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] data_w,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_stall,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  logic              wb_clr_s;
  logic              issue_set_s;
  logic              stall_s;
  logic              cnt_inc_s;
  logic              cnt_dec_s;
  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;
  logic              rb_a_s;
  logic              rb_b_s;

  // Control decode: writeback clear, stall and accepted issue
  always_comb begin
    wb_clr_s = write_en && (addr_w != {ADDR_W{1'b0}});
    // A writeback to the same register this cycle frees it in time, so no stall.
    if (issue_en && (issue_addr != {ADDR_W{1'b0}}) && busy_q[issue_addr] &&
        !(write_en && (addr_w == issue_addr))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
    issue_set_s = issue_en && (issue_addr != {ADDR_W{1'b0}}) && !stall_s;
  end

  // Next busy vector and count; on same-register collision the issue wins
  always_comb begin
    busy_d = busy_q;
    if (wb_clr_s) begin
      busy_d[addr_w] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_set_s) begin
      busy_d[issue_addr] = 1'b1;
    end else begin
      busy_d[0] = busy_d[0];
    end
    // Count real bit transitions only.
    // A writeback to a non-busy register does not decrement, so the count cannot wrap.
    cnt_inc_s = issue_set_s && !busy_q[issue_addr];
    cnt_dec_s = wb_clr_s && busy_q[addr_w] &&
                !(issue_set_s && (issue_addr == addr_w));
    cnt_d = cnt_q + {{ADDR_W{1'b0}}, cnt_inc_s} - {{ADDR_W{1'b0}}, cnt_dec_s};
  end

  // Scoreboard state: busy bits and busy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= {NREGS{1'b0}};
      cnt_q  <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Register storage; R0 is never written so it stays at its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_clr_s) begin
      regs_q[addr_w] <= data_w;
    end
  end

  // Read ports (optionally bypassing a same-cycle writeback)
  always_comb begin
    rd_a_s = regs_q[addr_a];
    rd_b_s = regs_q[addr_b];
    rb_a_s = busy_q[addr_a] && (addr_a != {ADDR_W{1'b0}});
    rb_b_s = busy_q[addr_b] && (addr_b != {ADDR_W{1'b0}});
`ifdef REGFILE_BYPASS_EN
    if (wb_clr_s && (addr_w == addr_a)) begin
      rd_a_s = data_w;
      rb_a_s = 1'b0;
    end else begin
      rd_a_s = rd_a_s;
    end
    if (wb_clr_s && (addr_w == addr_b)) begin
      rd_b_s = data_w;
      rb_b_s = 1'b0;
    end else begin
      rd_b_s = rd_b_s;
    end
`endif
    if (addr_a == {ADDR_W{1'b0}}) begin
      rd_a_s = {DATA_W{1'b0}};
    end else begin
      rd_a_s = rd_a_s;
    end
    if (addr_b == {ADDR_W{1'b0}}) begin
      rd_b_s = {DATA_W{1'b0}};
    end else begin
      rd_b_s = rd_b_s;
    end
  end

  // While reset is held, every combinational output is forced quiet.
  // This also covers the bypass path, which would otherwise forward data_w.
  assign data_a      = rst_n ? rd_a_s  : {DATA_W{1'b0}};
  assign data_b      = rst_n ? rd_b_s  : {DATA_W{1'b0}};
  assign busy_a      = rst_n ? rb_a_s  : 1'b0;
  assign busy_b      = rst_n ? rb_b_s  : 1'b0;
  assign issue_stall = rst_n ? stall_s : 1'b0;
  assign busy_cnt    = cnt_q;

endmodule
